// File: rtl/opcode_onehot_encoder.sv
// rtl/opcode_onehot_encoder.sv - RV64F major opcode to 10-bit one-hot class code, 2-entry skid buffer
// Optional feature macro: ONEHOT_CHECK_EN (sticky one-hot integrity checker driving code_err)
module opcode_onehot_encoder #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_code,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             code_err
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [9:0]       enc_code;
  logic             enc_illegal;
  logic             push;
  logic             pop;

  // head entry drives out_*, second entry holds the skid slot
  logic [9:0]       head_code;
  logic             head_illegal;
  logic [TAG_W-1:0] head_tag;
  logic [9:0]       sec_code;
  logic             sec_illegal;
  logic [TAG_W-1:0] sec_tag;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // combinational class lookup of the incoming opcode
  always_comb begin
    enc_code    = '0;
    enc_illegal = 1'b0;
    case (in_opcode)
      7'b0000011, 7'b0000111: enc_code[0] = 1'b1;
      7'b0100011, 7'b0100111: enc_code[1] = 1'b1;
      7'b0010011, 7'b0011011: enc_code[2] = 1'b1;
      7'b0110011, 7'b0111011: enc_code[3] = 1'b1;
      7'b1100011:             enc_code[4] = 1'b1;
      7'b1101111:             enc_code[5] = 1'b1;
      7'b1100111:             enc_code[6] = 1'b1;
      7'b0110111:             enc_code[7] = 1'b1;
      7'b0010111:             enc_code[8] = 1'b1;
      7'b1010011, 7'b1000011, 7'b1000111,
      7'b1001011, 7'b1001111: enc_code[9] = 1'b1;
      default:                enc_illegal = 1'b1;
    endcase
  end

  // occupancy: push-only grows, pop-only shrinks, push&pop holds
  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (push) state_nxt = S_ONE;
      S_ONE: begin
        if (push && !pop)      state_nxt = S_TWO;
        else if (pop && !push) state_nxt = S_EMPTY;
      end
      S_TWO:   if (pop) state_nxt = S_ONE;
      default: state_nxt = S_EMPTY;
    endcase
  end

  // state plus registered handshake flags so in_ready never depends on out_ready combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != S_TWO);
      out_valid <= (state_nxt != S_EMPTY);
    end
  end

  // entry storage: head refills from the skid slot or directly from the encoder
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_code    <= '0;
      head_illegal <= 1'b0;
      head_tag     <= '0;
      sec_code     <= '0;
      sec_illegal  <= 1'b0;
      sec_tag      <= '0;
    end else begin
      if (state == S_TWO && pop) begin
        head_code    <= sec_code;
        head_illegal <= sec_illegal;
        head_tag     <= sec_tag;
      end else if (push && (state == S_EMPTY || pop)) begin
        head_code    <= enc_code;
        head_illegal <= enc_illegal;
        head_tag     <= in_tag;
      end
      if (push && state == S_ONE && !pop) begin
        sec_code    <= enc_code;
        sec_illegal <= enc_illegal;
        sec_tag     <= in_tag;
      end
    end
  end

  assign out_code    = head_code;
  assign out_illegal = head_illegal;
  assign out_tag     = head_tag;

`ifdef ONEHOT_CHECK_EN
  logic code_ok;

  // a legal head must carry exactly one bit; an illegal head must carry none
  always_comb begin
    code_ok = 1'b0;
    if (head_illegal) code_ok = (head_code == 10'd0);
    else              code_ok = (head_code != 10'd0) && ((head_code & (head_code - 10'd1)) == 10'd0);
  end

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      code_err <= 1'b0;
    else if (out_valid && !code_ok) code_err <= 1'b1;
  end
`else
  assign code_err = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_onehot_encoder.sv
// tb/tb_opcode_onehot_encoder.sv - randomized self-checking bench for opcode_onehot_encoder
module tb_opcode_onehot_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_opcode;
  logic [4:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_code;
  logic       out_illegal;
  logic [4:0] out_tag;
  logic       code_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0] code;
    logic       ill;
    logic [4:0] tag;
  } ent_t;

  ent_t q[$];
  int   cls[128];
  logic [6:0] legal[19];

  always #5 clk = ~clk;

  opcode_onehot_encoder #(.TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_illegal(out_illegal), .out_tag(out_tag), .code_err(code_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t model(input logic [6:0] op, input logic [4:0] tag);
    ent_t e;
    e.tag  = tag;
    e.ill  = (cls[op] < 0);
    e.code = e.ill ? 10'd0 : (10'd1 << cls[op]);
    return e;
  endfunction

  // one clock: model the handshake from pre-edge inputs, then compare after the edge
  task automatic step();
    bit   m_push;
    bit   m_pop;
    ent_t e;
    m_push = in_valid && (q.size() < 2);
    m_pop  = out_ready && (q.size() > 0);
    e      = model(in_opcode, in_tag);
    @(posedge clk); #1;
    if (m_pop) void'(q.pop_front());
    if (m_push) q.push_back(e);
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      check("out_code", {22'd0, out_code}, {22'd0, q[0].code});
      check("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
      check("out_tag", {27'd0, out_tag}, {27'd0, q[0].tag});
    end
    check("code_err", {31'd0, code_err}, 32'd0);
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] tag);
    in_valid  = v;
    in_opcode = op;
    in_tag    = tag;
  endtask

  initial begin
    legal = '{7'b0000011, 7'b0000111, 7'b0100011, 7'b0100111, 7'b0010011, 7'b0011011,
              7'b0110011, 7'b0111011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
              7'b0010111, 7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111,
              7'b0000011};
    for (int i = 0; i < 128; i++) cls[i] = -1;
    cls[7'b0000011] = 0; cls[7'b0000111] = 0;
    cls[7'b0100011] = 1; cls[7'b0100111] = 1;
    cls[7'b0010011] = 2; cls[7'b0011011] = 2;
    cls[7'b0110011] = 3; cls[7'b0111011] = 3;
    cls[7'b1100011] = 4; cls[7'b1101111] = 5; cls[7'b1100111] = 6;
    cls[7'b0110111] = 7; cls[7'b0010111] = 8;
    cls[7'b1010011] = 9; cls[7'b1000011] = 9; cls[7'b1000111] = 9;
    cls[7'b1001011] = 9; cls[7'b1001111] = 9;

    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 7'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_code", {22'd0, out_code}, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_code_err", {31'd0, code_err}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // table sweep with the consumer always ready
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, legal[i], 5'(i));
      step();
    end
    drive(1'b1, 7'b0110011, 5'd3);
    step();
    check("op_onehot", {22'd0, out_code}, 32'h008);
    drive(1'b1, 7'b1010011, 5'd4);
    step();
    check("opfp_onehot", {22'd0, out_code}, 32'h200);
    check("opfp_legal", {31'd0, out_illegal}, 32'd0);
    drive(1'b1, 7'b1111111, 5'd9);
    step();
    check("illegal_code", {22'd0, out_code}, 32'd0);
    check("illegal_flag", {31'd0, out_illegal}, 32'd1);
    check("illegal_tag", {27'd0, out_tag}, 32'd9);
    drive(1'b0, 7'd0, 5'd0);
    step();

    // back-pressure: two entries fill the buffer, a third is held off
    out_ready = 1'b0;
    drive(1'b1, 7'b0110111, 5'd1);
    step();
    drive(1'b1, 7'b0010111, 5'd2);
    step();
    check("bp_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 7'b1101111, 5'd3);
    step();
    step();
    check("bp_head_lui", {22'd0, out_code}, 32'h080);
    drive(1'b0, 7'd0, 5'd0);
    out_ready = 1'b1;
    step();
    check("bp_second_auipc", {22'd0, out_code}, 32'h100);
    check("bp_second_tag", {27'd0, out_tag}, 32'd2);
    step();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // streaming: 100 random opcodes, one per cycle, in_ready must stay high
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 0) drive(1'b1, legal[$urandom_range(0, 18)], 5'($urandom));
      else                           drive(1'b1, 7'($urandom), 5'($urandom));
      step();
      check("stream_ready", {31'd0, in_ready}, 32'd1);
    end

    // random valid/ready mix
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 7'($urandom), 5'($urandom));
      out_ready = 1'($urandom);
      step();
    end

    // reset mid-stream with two entries held
    out_ready = 1'b0;
    drive(1'b0, 7'd0, 5'd0);
    step();
    step();
    drive(1'b1, 7'b1100011, 5'd5);
    step();
    drive(1'b1, 7'b1100111, 5'd6);
    step();
    check("mid_full", {31'd0, in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_code_err", {31'd0, code_err}, 32'd0);
    check("mid_rst_out_code", {22'd0, out_code}, 32'd0);
    q.delete();
    @(negedge clk) reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 7'b0000111, 5'd7);
    step();
    check("post_rst_accept", {22'd0, out_code}, 32'h001);
    drive(1'b0, 7'd0, 5'd0);
    step();

`ifdef ONEHOT_CHECK_EN
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 5'd1);
    step();
    drive(1'b0, 7'd0, 5'd0);
    @(negedge clk);
    force dut.head_code = 10'b0000000011;
    @(posedge clk); #1;
    check("chk_err_set", {31'd0, code_err}, 32'd1);
    release dut.head_code;
    repeat (2) @(posedge clk);
    #1;
    check("chk_err_sticky", {31'd0, code_err}, 32'd1);
    reset = 1'b1;
    #1;
    check("chk_err_clear", {31'd0, code_err}, 32'd0);
    @(negedge clk) reset = 1'b0;
    q.delete();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
